// File: rtl/mem_burst_ctrl_pkg.sv
// Shared definitions for the memory burst controller: default widths, line size,
// FSM state encoding and the line-crossing helper used when MEM_LINE_CHECK_EN is defined.
package mem_burst_ctrl_pkg;

    localparam int AW_DEF     = 9;
    localparam int DW_DEF     = 16;
    localparam int LINE_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // True when a burst starting at this offset within a line runs past the line end.
    function automatic logic crosses_line(input logic [1:0] addr_lo, input logic [1:0] len);
        return ({1'b0, addr_lo} + {1'b0, len}) > 3'(LINE_WORDS - 1);
    endfunction

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// Processor-side bus of the burst controller: request, write-data and read-data streams
// plus the done/err completion pulses.
//
// Handshake rule for req, wd and rd: a transfer happens on a rising clock edge where
// valid and ready are both high; valid never waits for ready.
interface mem_burst_ctrl_if #(
    parameter int AW = mem_burst_ctrl_pkg::AW_DEF,
    parameter int DW = mem_burst_ctrl_pkg::DW_DEF
);
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_len;
    logic          wd_valid;
    logic [DW-1:0] wd_data;
    logic          wd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready;
    logic          done;
    logic          err;

    modport master (
        output req_valid, req_wr, req_addr, req_len, wd_valid, wd_data, rd_ready,
        input  req_ready, wd_ready, rd_valid, rd_data, done, err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_len, wd_valid, wd_data, rd_ready,
        output req_ready, wd_ready, rd_valid, rd_data, done, err
    );
endinterface

// File: rtl/mem_burst_ctrl_addr_gen.sv
// Burst address generator: holds base, length and beat counter, and produces the
// memory address (wrapping at 2^AW) plus the last-beat flag.
module mem_burst_ctrl_addr_gen #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          load,
    input  logic          step,
    input  logic          idle,
    input  logic [AW-1:0] load_addr,
    input  logic [1:0]    load_len,
    output logic [AW-1:0] addr,
    output logic          last
);
    logic [AW-1:0] base;
    logic [1:0]    len;
    logic [1:0]    cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            base <= '0;
            len  <= '0;
            cnt  <= '0;
        end else if (load) begin
            base <= load_addr;
            len  <= load_len;
            cnt  <= '0;
        end else if (step) begin
            cnt <= cnt + 2'd1;
        end
    end

    assign addr = idle ? base : base + AW'(cnt);
    assign last = (cnt == len);

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst request sequencer in front of the 512x16 memory; sole owner of mem_we.
// Optional MEM_LINE_CHECK_EN rejects bursts that cross a 4-word line (done+err, no access).
module mem_burst_ctrl
    import mem_burst_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_b,
    mem_burst_ctrl_if.slave bus,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q,
    output state_t        state_dbg
);
    state_t        state;
    logic          rd_valid_q;
    logic [DW-1:0] rd_data_q;
    logic          done_q;
    logic          err_q;
    logic          last;
    logic          accept;
    logic          reject;
    logic          can_take;
    logic          step;

    assign accept   = (state == ST_IDLE) && bus.req_valid;
    assign can_take = !rd_valid_q || bus.rd_ready;

`ifdef MEM_LINE_CHECK_EN
    assign reject = crosses_line(bus.req_addr[1:0], bus.req_len);
`else
    assign reject = 1'b0;
`endif

    // The counter is left at the last beat on a write so IDLE can still show base.
    assign step = ((state == ST_WRITE) && bus.wd_valid && !last) ||
                  ((state == ST_READ) && can_take);

    mem_burst_ctrl_addr_gen #(.AW(AW)) u_addr_gen (
        .clk       (clk),
        .rst_b     (rst_b),
        .load      (accept),
        .step      (step),
        .idle      (state == ST_IDLE),
        .load_addr (bus.req_addr),
        .load_len  (bus.req_len),
        .addr      (mem_addr),
        .last      (last)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= ST_IDLE;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if ((state == ST_IDLE || state == ST_WRITE) && rd_valid_q && bus.rd_ready)
                rd_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (reject) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            state <= bus.req_wr ? ST_WRITE : ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.wd_valid && last) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (can_take) begin
                        rd_data_q  <= mem_q;
                        rd_valid_q <= 1'b1;
                        if (last) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (bus.rd_ready) begin
                        rd_valid_q <= 1'b0;
                        state      <= ST_IDLE;
                        done_q     <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Write strobe is combinational from state so an async reset drops it at once.
    assign mem_we       = (state == ST_WRITE) && bus.wd_valid;
    assign mem_d        = (state == ST_WRITE) ? bus.wd_data : '0;
    assign bus.wd_ready = (state == ST_WRITE);
    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign state_dbg    = state;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl: table of write/read bursts plus hand sequences for
// read backpressure, back-to-back requests in the done cycle and reset mid-burst.
module tb_mem_burst_ctrl;
    import mem_burst_ctrl_pkg::*;

    logic        clk;
    logic        rst_b;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [15:0] mem_d;
    logic [15:0] mem_q;
    state_t      state_dbg;

    logic [15:0] mem [512] = '{default: 16'h0000};

    int n_checks = 0;
    int n_fail   = 0;

    mem_burst_ctrl_if #(.AW(9), .DW(16)) bus ();

    mem_burst_ctrl #(.AW(9), .DW(16)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .bus       (bus),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_d     (mem_d),
        .mem_q     (mem_q),
        .state_dbg (state_dbg)
    );

    // clock / memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_d;
    end
    assign mem_q = mem[mem_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [8:0]       addr;
        logic [1:0]       len;
        logic [15:0]      d0;
        logic [3:0][8:0]  ea;
        logic             exp_err;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 9'h000;
        bus.req_len   = 2'd0;
        bus.wd_valid  = 1'b0;
        bus.wd_data   = 16'h0000;
        bus.rd_ready  = 1'b0;
    endtask

    task automatic issue_req(input logic wr, input logic [8:0] a, input logic [1:0] l);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = a;
        bus.req_len   = l;
        #1;
        check("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic expect_reject();
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        check("reject_done", 32'(bus.done), 32'd1);
        check("reject_err", 32'(bus.err), 32'd1);
        check("reject_req_ready", 32'(bus.req_ready), 32'd1);
        check("reject_wd_ready", 32'(bus.wd_ready), 32'd0);
        check("reject_mem_we", 32'(mem_we), 32'd0);
        check("reject_rd_valid", 32'(bus.rd_valid), 32'd0);
    endtask

    task automatic do_write(input vec_t v);
        logic [15:0] d;
        issue_req(1'b1, v.addr, v.len);
        if (v.exp_err) begin
            expect_reject();
        end else begin
            for (int i = 0; i <= int'(v.len); i++) begin
                d = v.d0 + 16'(i);
                @(negedge clk);
                bus.req_valid = 1'b0;
                bus.wd_valid  = 1'b1;
                bus.wd_data   = d;
                #1;
                check("wr_mem_we", 32'(mem_we), 32'd1);
                check("wr_wd_ready", 32'(bus.wd_ready), 32'd1);
                check("wr_mem_addr", 32'(mem_addr), 32'(v.ea[i]));
                check("wr_mem_d", 32'(mem_d), 32'(d));
                check("wr_done_low", 32'(bus.done), 32'd0);
            end
            @(negedge clk);
            bus.wd_valid = 1'b0;
            #1;
            check("wr_done", 32'(bus.done), 32'd1);
            check("wr_err", 32'(bus.err), 32'd0);
            check("wr_req_ready_after", 32'(bus.req_ready), 32'd1);
            check("wr_mem_we_after", 32'(mem_we), 32'd0);
        end
    endtask

    task automatic do_read(input vec_t v);
        issue_req(1'b0, v.addr, v.len);
        if (v.exp_err) begin
            expect_reject();
        end else begin
            bus.rd_ready = 1'b1;
            @(negedge clk);
            bus.req_valid = 1'b0;
            #1;
            check("rd_not_yet_valid", 32'(bus.rd_valid), 32'd0);
            for (int i = 0; i <= int'(v.len); i++) begin
                @(negedge clk);
                #1;
                check("rd_valid", 32'(bus.rd_valid), 32'd1);
                check("rd_data", 32'(bus.rd_data), 32'(v.d0 + 16'(i)));
                check("rd_done_low", 32'(bus.done), 32'd0);
            end
            @(negedge clk);
            #1;
            check("rd_done", 32'(bus.done), 32'd1);
            check("rd_err", 32'(bus.err), 32'd0);
            check("rd_valid_cleared", 32'(bus.rd_valid), 32'd0);
            check("rd_req_ready_after", 32'(bus.req_ready), 32'd1);
            bus.rd_ready = 1'b0;
        end
    endtask

    initial begin
        vecs[0] = '{addr: 9'h010, len: 2'd3, d0: 16'hA000,
                    ea: {9'h013, 9'h012, 9'h011, 9'h010}, exp_err: 1'b0};
        vecs[1] = '{addr: 9'h1FF, len: 2'd1, d0: 16'hB000,
                    ea: {9'h000, 9'h000, 9'h000, 9'h1FF},
`ifdef MEM_LINE_CHECK_EN
                    exp_err: 1'b1};
`else
                    exp_err: 1'b0};
`endif
        vecs[2] = '{addr: 9'h0A2, len: 2'd0, d0: 16'hC000,
                    ea: {9'h000, 9'h000, 9'h000, 9'h0A2}, exp_err: 1'b0};
        vecs[3] = '{addr: 9'h104, len: 2'd2, d0: 16'hD000,
                    ea: {9'h000, 9'h106, 9'h105, 9'h104}, exp_err: 1'b0};

        // reset block
        idle_inputs();
        rst_b = 1'b0;
        #3;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        #1;
        check("idle_req_ready", 32'(bus.req_ready), 32'd1);
        check("idle_mem_we", 32'(mem_we), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_state", 32'(state_dbg), 32'(ST_IDLE));

        // table: write every burst, check memory image, read every burst back
        for (int k = 0; k < 4; k++) do_write(vecs[k]);
        for (int k = 0; k < 4; k++) begin
            if (vecs[k].exp_err) begin
                check("mem_untouched_lo", 32'(mem[9'h1FF]), 32'd0);
                check("mem_untouched_hi", 32'(mem[9'h000]), 32'd0);
            end else begin
                for (int i = 0; i <= int'(vecs[k].len); i++)
                    check("mem_image", 32'(mem[vecs[k].ea[i]]), 32'(vecs[k].d0 + 16'(i)));
            end
        end
        for (int k = 0; k < 4; k++) do_read(vecs[k]);

        // read with backpressure: first beat held three cycles, second beat not lost
        bus.rd_ready = 1'b0;
        issue_req(1'b0, 9'h010, 2'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("bp_hold_valid", 32'(bus.rd_valid), 32'd1);
            check("bp_hold_data", 32'(bus.rd_data), 32'hA000);
            check("bp_hold_state", 32'(state_dbg), 32'(ST_READ));
        end
        @(negedge clk);
        bus.rd_ready = 1'b1;
        #1;
        check("bp_release_data", 32'(bus.rd_data), 32'hA000);
        @(negedge clk);
        #1;
        check("bp_second_valid", 32'(bus.rd_valid), 32'd1);
        check("bp_second_data", 32'(bus.rd_data), 32'hA001);
        check("bp_drain_state", 32'(state_dbg), 32'(ST_DRAIN));
        @(negedge clk);
        #1;
        check("bp_done", 32'(bus.done), 32'd1);
        check("bp_rd_valid_cleared", 32'(bus.rd_valid), 32'd0);
        bus.rd_ready = 1'b0;

        // new request accepted in the cycle done is high
        issue_req(1'b1, 9'h020, 2'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.wd_valid  = 1'b1;
        bus.wd_data   = 16'hE000;
        #1;
        check("b2b_write_we", 32'(mem_we), 32'd1);
        @(negedge clk);
        bus.wd_valid  = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 9'h020;
        bus.req_len   = 2'd0;
        bus.rd_ready  = 1'b1;
        #1;
        check("b2b_done", 32'(bus.done), 32'd1);
        check("b2b_req_ready_in_done", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        check("b2b_read_state", 32'(state_dbg), 32'(ST_READ));
        @(negedge clk);
        #1;
        check("b2b_rd_valid", 32'(bus.rd_valid), 32'd1);
        check("b2b_rd_data", 32'(bus.rd_data), 32'hE000);
        @(negedge clk);
        #1;
        check("b2b_rd_done", 32'(bus.done), 32'd1);
        bus.rd_ready = 1'b0;

        // reset during the third write beat
        issue_req(1'b1, 9'h040, 2'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            bus.wd_valid  = 1'b1;
            bus.wd_data   = 16'hF000 + 16'(i);
            #1;
            check("rst_mid_we_before", 32'(mem_we), 32'd1);
        end
        rst_b = 1'b0;
        #1;
        check("rst_mid_we_drop", 32'(mem_we), 32'd0);
        check("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_mid_done", 32'(bus.done), 32'd0);
        bus.wd_valid = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        check("rst_rel_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        #1;
        check("rst_rel_no_done", 32'(bus.done), 32'd0);
        check("rst_rel_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rst_beat1_written", 32'(mem[9'h040]), 32'hF000);
        check("rst_beat2_written", 32'(mem[9'h041]), 32'hF001);
        check("rst_beat3_dropped", 32'(mem[9'h042]), 32'h0000);
        check("rst_beat4_dropped", 32'(mem[9'h043]), 32'h0000);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
